bcd_tick_counter: RTL
=====================

// Module: bcd_tick_counter
// PURPOSE
//   Multi-digit BCD up/down counter that consumes the 1-cycle enable pulse from
//   the rate generator and advances one count per pulse. It sits between the
//   rate generator and the 7-segment display driver.
//   A small run-control FSM provides start/stop, clear, preset load, wrap or
//   saturate at the limits, and a terminal-count pulse.
// PARAMETERS
//   DIGITS  4  number of BCD digits; count range 0 .. 10^DIGITS-1
//   WRAP    1  1: wrap at the limits and keep running; 0: saturate and enter DONE
// PORTS
//   clk         in   1          clock
//   rst         in   1          reset, synchronous, active-high
//   tick        in   1          count enable; 1-cycle pulse from the rate generator
//   start_stop  in   1          1-cycle pulse (debounced upstream); toggles run/stop
//   clr         in   1          level; forces the count to 0
//   load        in   1          level; presets the count from load_val
//   load_val    in   4*DIGITS   BCD preset value; digit 0 is in bits [3:0]
//   up_dn       in   1          1 = count up, 0 = count down; sampled on each tick
//   bcd         out  4*DIGITS   current count, packed BCD (registered)
//   running     out  1          1 while the FSM is in RUN (registered)
//   tc          out  1          1-cycle pulse when the count passes a limit
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): bcd=0, state=STOP, running=0, tc=0.
//   Priority per edge: rst > clr > load > tick. A tick in a clr or load cycle is dropped.
//   FSM states:
//     STOP -> RUN on start_stop.
//     RUN  -> STOP on start_stop.
//     RUN  -> DONE on a limit hit with WRAP=0.
//     DONE -> STOP on clr or load. start_stop is ignored in DONE.
//     clr and load do not change STOP or RUN.
//   Counting: only in RUN, and only on a clk edge with tick=1.
//     The new value appears on bcd the following cycle (1-cycle latency).
//     Up: digit 0 increments; a digit at 9 becomes 0 and carries to the next digit.
//     Down: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
//   Limits: up from all-9s, or down from all-0s.
//     WRAP=1: up from all-9s gives all-0s; down from all-0s gives all-9s;
//       state stays RUN; tc=1 in the same cycle the wrapped value is shown.
//     WRAP=0: the count holds at the limit, state goes to DONE, running=0,
//       tc=1 for one cycle. Further ticks are ignored.
//   Simultaneous start_stop and tick while in RUN: the tick is applied
//     (decided on the pre-edge state), then the state goes to STOP.
//   Simultaneous start_stop and tick while in STOP: the tick is ignored,
//     then the state goes to RUN.
//   load: any load_val digit greater than 9 is clamped to 9 before it is stored.
//   tc is 0 in every cycle that is not a limit crossing, and 0 on clr, load, or reset.
//   Reset mid-run: on the next edge bcd=0 and state=STOP regardless of other inputs.
//   up_dn may change between ticks; there is no other restriction on it.
// TESTING (DIGITS=4 unless noted)
//   1. Reset, start_stop, then 3 ticks with up_dn=1 -> bcd=0x0003, running=1, tc never set.
//   2. load 0x9998, run, 2 ticks up -> bcd 0x9999 then 0x0000; tc=1 only with 0x0000.
//   3. WRAP=0: load 0x0001, run, 3 ticks down -> bcd 0x0000 held; DONE; running=0;
//      tc is a single pulse; start_stop is ignored; clr returns the state to STOP.
//   4. Run at 0x0041, start_stop and tick in the same cycle -> bcd=0x0042,
//      running=0; a further tick leaves bcd=0x0042.
//   5. load_val=0x9AF3 -> bcd=0x9993. clr, load and tick in the same cycle -> bcd=0x0000.
//   6. Running at 0x1234, rst pulsed for 1 cycle with tick=1 -> bcd=0x0000,
//      running=0, tc=0.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by rate-generator tick pulses, with
// run/stop/done control, clear, clamped preset load, wrap-or-saturate limits and tc pulse.

module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  output logic [3:0] q,
  output logic       lim
);
  always_comb begin
    lim = up ? (d == 4'd9) : (d == 4'd0);
    if (up) q = lim ? 4'd0 : d + 4'd1;
    else    q = lim ? 4'd9 : d - 4'd1;
  end
endmodule

module bcd_tick_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                up_dn,
  output logic [4*DIGITS-1:0] bcd,
  output logic                running,
  output logic                tc
);
  typedef enum logic [1:0] {S_STOP, S_RUN, S_DONE} state_t;

  state_t state, state_nx;
  logic   running_nx;

  logic [DIGITS-1:0][3:0] cnt, cnt_nx, dq, ld_c;
  logic [DIGITS-1:0]      dlim;
  logic [DIGITS:0]        en;
  logic                   adv, hit;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (.d(cnt[g]), .up(up_dn), .q(dq[g]), .lim(dlim[g]));
    end
  endgenerate

  // A digit steps only when every lower digit is rolling over; en[DIGITS]
  // is therefore set exactly when the whole count sits at the limit.
  always_comb begin
    en[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      en[i+1]   = en[i] & dlim[i];
      cnt_nx[i] = en[i] ? dq[i] : cnt[i];
      ld_c[i]   = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  assign adv = tick && (state == S_RUN) && !clr && !load;
  assign hit = adv && en[DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= ld_c;
      tc  <= 1'b0;
    end else if (adv) begin
      if (!hit || WRAP) cnt <= cnt_nx;
      tc <= hit;
    end else begin
      tc <= 1'b0;
    end
  end

  assign bcd = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_STOP;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= running_nx;
    end
  end

  // A saturating limit hit outranks a coincident start_stop.
  always_comb begin
    state_nx = state;
    case (state)
      S_STOP:  if (start_stop) state_nx = S_RUN;
      S_RUN:   if (hit && !WRAP) state_nx = S_DONE;
               else if (start_stop) state_nx = S_STOP;
      S_DONE:  if (clr || load) state_nx = S_STOP;
      default: state_nx = S_STOP;
    endcase
  end

  always_comb begin
    running_nx = (state_nx == S_RUN);
  end
endmodule
